// File: rtl/pfb_ctrl_pkg.sv
// Shared types and latency constants for the PFB MAC chain sequencer.
package pfb_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } ctrl_state_t;

    localparam int unsigned COEF_LAT    = 1;
    localparam int unsigned AREG        = 2;
    localparam int unsigned MREG        = 1;
    localparam int unsigned PREG        = 1;
    // Remaining stages come from the systolic cascade taps along the chain.
    localparam int unsigned CASCADE_LAT = 23;
    localparam int unsigned DEF_PIPE_LAT = COEF_LAT + AREG + MREG + PREG + CASCADE_LAT;

endpackage

// File: rtl/ce_delay_line.sv
// Clock-enabled shift register; advances in lockstep with the MAC chain.
module ce_delay_line #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ce,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] stages [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stages[i] <= '0;
            end
        end else if (ce) begin
            stages[0] <= din;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign dout = stages[DEPTH-1];

endmodule

// File: rtl/pfb_mac_ctrl.sv
// Sequencer for a DSP48 PFB MAC chain: phase addressing, chain-wide clock
// enable and valid/phase/last tracking through the chain latency.
module pfb_mac_ctrl
    import pfb_ctrl_pkg::*;
#(
    parameter int unsigned PHASE_W  = 11,
    parameter int unsigned PIPE_LAT = DEF_PIPE_LAT,
    parameter int unsigned DATA_W   = 48
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [PHASE_W-1:0] nfft_m1,
    input  logic               s_axis_tvalid,
    output logic               s_axis_tready,
    output logic [PHASE_W-1:0] coef_addr,
    output logic               mac_ce,
    input  logic [DATA_W-1:0]  mac_p,
    output logic               m_axis_tvalid,
    input  logic               m_axis_tready,
    output logic [DATA_W-1:0]  m_axis_tdata,
    output logic [PHASE_W-1:0] m_axis_tuser,
    output logic               m_axis_tlast,
    output logic               busy
);

    localparam int unsigned CNT_W = $clog2(PIPE_LAT + 1) + 1;

    ctrl_state_t        state, state_next;
    logic [PHASE_W-1:0] phase;
    logic [PHASE_W-1:0] nfft_lat;
    logic [CNT_W-1:0]   in_flight;
    logic               xfer, wrap, pop, start;
    logic [PHASE_W+1:0] dl_in, dl_out;

    assign mac_ce = m_axis_tready | ~m_axis_tvalid;
    // With enable low at a frame boundary, stop accepting so the frame closes on the wrap.
    assign s_axis_tready = (state == RUN) && mac_ce && (enable || (phase != '0));
    assign xfer      = s_axis_tvalid & s_axis_tready;
    assign wrap      = xfer && (phase == nfft_lat);
    assign pop       = m_axis_tvalid & m_axis_tready;
    assign coef_addr = phase;
    assign busy      = (state != IDLE);
    assign m_axis_tdata = mac_p;

    always_comb begin
        state_next = state;
        start      = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_next = RUN;
                    start      = 1'b1;
                end
            end
            RUN: begin
                if (!enable && (phase == '0) && !xfer) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if ((in_flight == '0) && !m_axis_tvalid) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase    <= '0;
            nfft_lat <= '1;
        end else if (start) begin
            phase    <= '0;
            nfft_lat <= nfft_m1;
        end else if (wrap) begin
            phase    <= '0;
            nfft_lat <= nfft_m1;
        end else if (xfer) begin
            phase    <= phase + PHASE_W'(1);
        end
    end

    // Samples inside the chain, including the one presented at the output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_flight <= '0;
        end else begin
            in_flight <= in_flight + CNT_W'(xfer) - CNT_W'(pop);
        end
    end

    assign dl_in = {xfer, wrap, phase};

    ce_delay_line #(
        .W     (PHASE_W + 2),
        .DEPTH (PIPE_LAT)
    ) u_track (
        .clk   (clk),
        .reset (reset),
        .ce    (mac_ce),
        .din   (dl_in),
        .dout  (dl_out)
    );

    assign {m_axis_tvalid, m_axis_tlast, m_axis_tuser} = dl_out;

endmodule
